ram_access_ctrl: RTL and testbench

Initiator-side controller for the project's single-clock block RAM (registered read address, write-enable port). It accepts read/write requests over a valid/ready handshake, drives the RAM port (`ram_we`, `ram_a`, `ram_din`) and returns read data with a response strobe aligned to the RAM's one-cycle read latency. An optional clear sequencer fills the whole RAM with a constant value. It sits between game/VGA logic and the RAM instance.

---
 rtl/ram_access_ctrl_pkg.sv | 10 +
 rtl/ram_sweep_cnt.sv | 47 ++++
 rtl/ram_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types for the block-RAM access controller.
// Contents: state_e, the controller state encoding (ST_IDLE, ST_CLEAR).
package ram_access_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage : ram_access_ctrl_pkg

// File: rtl/ram_sweep_cnt.sv
// Loadable address counter that steps the clear sweep through the RAM.
// The module exists only when RAM_ACCESS_CTRL_CLEAR_EN is defined.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load_i    synchronously loads the counter with 0 (has priority over en_i)
//   en_i      increments the counter by one
//   cnt_o     current sweep address
//   tc_o      terminal count, high while cnt_o == DEPTH-1
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
module ram_sweep_cnt #(
  parameter int unsigned ADDRESSWIDTH = 6,
  parameter int unsigned DEPTH        = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    en_i,
  output logic [ADDRESSWIDTH-1:0] cnt_o,
  output logic                    tc_o
);

  logic [ADDRESSWIDTH-1:0] cnt_q;
  logic [ADDRESSWIDTH-1:0] cnt_d;

  // Next count: a load wins over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ADDRESSWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == ADDRESSWIDTH'(DEPTH - 1));

endmodule : ram_sweep_cnt
`endif

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for a single-clock block RAM whose read address
// is registered (data appears one cycle after the address is presented).
// Requests arrive over a valid/ready handshake; reads answer one cycle later.
// Optional clear sweep, built only when RAM_ACCESS_CTRL_CLEAR_EN is defined,
// fills every valid word with a constant.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_we/req_addr/req_data  request (we=1 write, 0 read)
//   req_ready                        request accepted on valid & ready
//   rsp_valid/rsp_data               read response (data 0 when not valid)
//   addr_err                         pulse after accepting addr >= DEPTH
//   clr_start/clr_value              start a clear sweep with a fill value
//   busy/clr_done                    sweep running / one-cycle end pulse
//   ram_we/ram_a/ram_din/ram_spo     RAM port
module ram_access_ctrl #(
  parameter int unsigned ADDRESSWIDTH = 6,
  parameter int unsigned BITWIDTH     = 10,
  parameter int unsigned DEPTH        = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDRESSWIDTH-1:0] req_addr,
  input  logic [BITWIDTH-1:0]     req_data,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [BITWIDTH-1:0]     rsp_data,
  output logic                    addr_err,
  input  logic                    clr_start,
  input  logic [BITWIDTH-1:0]     clr_value,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    ram_we,
  output logic [ADDRESSWIDTH-1:0] ram_a,
  output logic [BITWIDTH-1:0]     ram_din,
  input  logic [BITWIDTH-1:0]     ram_spo
);
  import ram_access_ctrl_pkg::*;

  logic req_fire_c;
  logic in_range_c;
  logic rsp_valid_q;
  logic rsp_oor_q;
  logic addr_err_q;

  assign in_range_c = (32'(req_addr) < DEPTH);
  assign req_fire_c = req_valid & req_ready;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
  state_e                  state_q;
  logic [BITWIDTH-1:0]     clr_value_q;
  logic                    clr_done_q;
  logic [ADDRESSWIDTH-1:0] sweep_cnt;
  logic                    sweep_tc;
  logic                    sweep_load_c;

  // A clear request wins over a simultaneous access request.
  assign sweep_load_c = (state_q == ST_IDLE) & clr_start;
  assign req_ready    = ~rst & (state_q == ST_IDLE) & ~clr_start;
  assign busy         = (state_q == ST_CLEAR);
  assign clr_done     = clr_done_q;

  ram_sweep_cnt #(
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .DEPTH        (DEPTH)
  ) u_sweep_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (sweep_load_c),
    .en_i   (busy),
    .cnt_o  (sweep_cnt),
    .tc_o   (sweep_tc)
  );

  // Sweep FSM; the fill value is captured at start so it may change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_value_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q     <= ST_CLEAR;
            clr_value_q <= clr_value;
          end
        end
        ST_CLEAR: begin
          if (sweep_tc) begin
            state_q    <= ST_IDLE;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_clr_c;

  assign unused_clr_c = ^{clr_start, clr_value};
  assign req_ready    = ~rst;
  assign busy         = 1'b0;
  assign clr_done     = 1'b0;
`endif

  // RAM port: sweep writes while busy, else pass accepted in-range requests.
  always_comb begin
    ram_we  = 1'b0;
    ram_a   = '0;
    ram_din = '0;
    if (req_fire_c && in_range_c) begin
      ram_we  = req_we;
      ram_a   = req_addr;
      ram_din = req_we ? req_data : '0;
    end
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    if (busy) begin
      ram_we  = 1'b1;
      ram_a   = sweep_cnt;
      ram_din = clr_value_q;
    end
`endif
  end

  // Response/error flags line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_oor_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      rsp_valid_q <= req_fire_c & ~req_we;
      rsp_oor_q   <= req_fire_c & ~req_we & ~in_range_c;
      addr_err_q  <= req_fire_c & ~in_range_c;
    end
  end

  assign rsp_valid = rsp_valid_q;
  // Out-of-range reads return zero instead of whatever word the RAM presents.
  assign rsp_data  = (rsp_valid_q && !rsp_oor_q) ? ram_spo : '0;
  assign addr_err  = addr_err_q;

endmodule : ram_access_ctrl

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural registered-address RAM.
// Clear-sweep steps are built when RAM_ACCESS_CTRL_CLEAR_EN is defined.
module tb_ram_access_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned BW    = 10;
  localparam int unsigned DEPTH = 34;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_data;
  logic          req_ready;
  logic          rsp_valid;
  logic [BW-1:0] rsp_data;
  logic          addr_err;
  logic          clr_start;
  logic [BW-1:0] clr_value;
  logic          busy;
  logic          clr_done;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [BW-1:0] ram_din;
  logic [BW-1:0] ram_spo;

  int nvec;
  int nerr;

  ram_access_ctrl #(
    .ADDRESSWIDTH (AW),
    .BITWIDTH     (BW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .addr_err  (addr_err),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .busy      (busy),
    .clr_done  (clr_done),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_din   (ram_din),
    .ram_spo   (ram_spo)
  );

  // Behavioural RAM: synchronous write, registered read address.
  logic [BW-1:0] mem [64];
  logic [AW-1:0] a_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_din;
    a_q <= ram_a;
  end
  assign ram_spo = mem[a_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    int  cnt;
    logic ok;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    clr_start = 1'b0;
    clr_value = '0;
    drive(1'b0, 1'b0, '0, '0);

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_outs", 32'({rsp_valid, addr_err, busy, clr_done, ram_we}), 32'h0);
    chk("rst_port", 32'({ram_a, ram_din, rsp_data}), 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'h1);

    // Write 0x155 to addr 5, pass-through in the same cycle
    drive(1'b1, 1'b1, 6'd5, 10'h155);
    #1;
    chk("wr5_port", 32'({ram_we, ram_a, ram_din}), 32'({1'b1, 6'd5, 10'h155}));
    step();
    chk("wr5_no_rsp", 32'(rsp_valid), 32'h0);
    // Read addr 5 right after the write
    drive(1'b1, 1'b0, 6'd5, '0);
    #1;
    chk("rd5_port", 32'({ram_we, ram_a}), 32'({1'b0, 6'd5}));
    step();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("rd5_rsp", 32'({rsp_valid, rsp_data, addr_err}), 32'({1'b1, 10'h155, 1'b0}));
    step();
    chk("rd5_rsp_end", 32'({rsp_valid, rsp_data}), 32'h0);

    // Writes 1,2,3 to addrs 0..2 then back-to-back reads
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, AW'(i), BW'(i + 1));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0);
      step();
      chk($sformatf("b2b_rd%0d", i), 32'({rsp_valid, rsp_data}), 32'({1'b1, BW'(i + 1)}));
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("b2b_end", 32'(rsp_valid), 32'h0);

    // Out-of-range write: no RAM write, addr_err next cycle
    drive(1'b1, 1'b1, 6'd40, 10'h2AA);
    #1;
    chk("oor_wr_ready", 32'(req_ready), 32'h1);
    chk("oor_wr_nowe", 32'(ram_we), 32'h0);
    step();
    chk("oor_wr_err", 32'({addr_err, rsp_valid}), 32'({1'b1, 1'b0}));
    // Out-of-range read: zero data even though RAM word 0 holds 1
    drive(1'b1, 1'b0, 6'd40, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("oor_rd", 32'({addr_err, rsp_valid, rsp_data}), 32'({1'b1, 1'b1, 10'h0}));
    step();
    chk("oor_err_end", 32'({addr_err, rsp_valid}), 32'h0);

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    // Clear start collides with a read of addr 3
    clr_start = 1'b1;
    clr_value = 10'h3FF;
    drive(1'b1, 1'b0, 6'd3, '0);
    #1;
    chk("clr_collide_ready", 32'({req_ready, ram_we}), 32'h0);
    step();
    clr_start = 1'b0;
    clr_value = 10'h000;
    #1;
    chk("clr_first", 32'({busy, ram_we, ram_a, ram_din}), 32'({1'b1, 1'b1, 6'd0, 10'h3FF}));
    chk("clr_no_rsp", 32'(rsp_valid), 32'h0);
    cnt = 0;
    ok  = 1'b1;
    while (busy === 1'b1 && cnt < 40) begin
      ok = ok & (ram_we === 1'b1) & (ram_a === AW'(cnt)) & (ram_din === 10'h3FF)
              & (req_ready === 1'b0) & (clr_done === 1'b0);
      clr_start = (cnt == 5);
      cnt++;
      step();
    end
    clr_start = 1'b0;
    #1;
    chk("clr_sweep_port", 32'(ok), 32'h1);
    chk("clr_busy_cycles", 32'(cnt), 32'(DEPTH));
    chk("clr_done_pulse", 32'({clr_done, busy, req_ready}), 32'({1'b1, 1'b0, 1'b1}));
    step();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("clr_pending_rd3", 32'({rsp_valid, rsp_data, clr_done}), 32'({1'b1, 10'h3FF, 1'b0}));
    drive(1'b1, 1'b0, 6'd0, '0);
    step();
    chk("clr_rd0", 32'({rsp_valid, rsp_data}), 32'({1'b1, 10'h3FF}));
    drive(1'b1, 1'b0, 6'd33, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("clr_rd33", 32'({rsp_valid, rsp_data}), 32'({1'b1, 10'h3FF}));
    step();

    // Reset at cycle 10 of a sweep
    clr_start = 1'b1;
    clr_value = 10'h155;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("abort_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_rst_outs", 32'({busy, ram_we, req_ready, clr_done, rsp_valid, addr_err}), 32'h0);
    chk("abort_rst_port", 32'({ram_a, ram_din}), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_idle", 32'({req_ready, busy}), 32'({1'b1, 1'b0}));
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ok = ok & (clr_done === 1'b0) & (busy === 1'b0);
    end
    chk("abort_no_done", 32'(ok), 32'h1);
`else
    // Clear inputs have no effect without the sweep feature
    clr_start = 1'b1;
    clr_value = 10'h3FF;
    drive(1'b1, 1'b0, 6'd2, '0);
    #1;
    chk("noclr_ready", 32'({req_ready, ram_we, ram_a}), 32'({1'b1, 1'b0, 6'd2}));
    step();
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("noclr_rd2", 32'({rsp_valid, rsp_data, busy, clr_done}), 32'({1'b1, 10'h003, 1'b0, 1'b0}));
    step();
    clr_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("noclr_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("noclr_ready_after", 32'(req_ready), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_ram_access_ctrl
